// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch (IF) and data (DM) ports.
// One transaction in flight; DM wins collisions unless IF has been passed over STARVE_MAX times.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [2:0]        dm_op_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [2:0]        mem_op_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);

    localparam int unsigned WaitW   = $clog2(MEM_LAT + 1);
    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
    localparam logic [WaitW-1:0]   WaitInit  = WaitW'(MEM_LAT - 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q;
    logic [WaitW-1:0]    wait_q;
    logic [StarveW-1:0]  starve_q;
    logic [StarveW-1:0]  starve_d;
    logic                both_req;
    logic                starve_hit;
    logic                grant_dm;

    logic                mem_en_q;
    logic                mem_we_q;
    logic [2:0]          mem_op_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;
    logic                if_ack_q;
    logic                dm_ack_q;
    logic                owner_q;

    // Count stops at StarveMax because reaching it forces an IF grant that clears it.
    always_comb begin
        both_req   = if_req_i & dm_req_i;
        starve_hit = both_req && (starve_q == StarveMax);
        grant_dm   = dm_req_i & ~starve_hit;
        starve_d   = '0;
        if (both_req && !starve_hit) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_op_q    <= 3'b000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            mem_en_q <= 1'b0;
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (if_req_i || dm_req_i) begin
                        state_q  <= StIssue;
                        mem_en_q <= 1'b1;
                        starve_q <= starve_d;
                        owner_q  <= grant_dm;
                        if (grant_dm) begin
                            mem_we_q    <= dm_we_i;
                            mem_op_q    <= dm_op_i;
                            mem_addr_q  <= dm_addr_i;
                            mem_wdata_q <= dm_wdata_i;
                        end else begin
                            mem_we_q   <= 1'b0;
                            mem_op_q   <= 3'b000;
                            mem_addr_q <= if_addr_i;
                        end
                    end
                end
                StIssue: begin
                    wait_q  <= WaitInit;
                    state_q <= StWait;
                end
                StWait: begin
                    if (wait_q == '0) begin
                        if (!owner_q) begin
                            if_rdata_q <= mem_rdata_i;
                            if_ack_q   <= 1'b1;
                        end else begin
                            if (!mem_we_q) begin
                                dm_rdata_q <= mem_rdata_i;
                            end
                            dm_ack_q <= 1'b1;
                        end
                        state_q <= StResp;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign if_stall_o  = if_req_i & ~if_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign mem_stall_o = dm_req_i & ~dm_ack_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_op_o    = mem_op_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != StIdle);
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vector table, hand sequences for collision,
// starvation and mid-transaction reset, then random traffic against a slot-timing model.
module tb_unified_mem_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_op;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_stall;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;

    unified_mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_LAT   (LAT),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_rdata_o (if_rdata),
        .if_ack_o   (if_ack),
        .if_stall_o (if_stall),
        .dm_req_i   (dm_req),
        .dm_we_i    (dm_we),
        .dm_op_i    (dm_op),
        .dm_addr_i  (dm_addr),
        .dm_wdata_i (dm_wdata),
        .dm_rdata_o (dm_rdata),
        .dm_ack_o   (dm_ack),
        .mem_stall_o(mem_stall),
        .mem_en_o   (mem_en),
        .mem_we_o   (mem_we),
        .mem_op_o   (mem_op),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .busy_o     (busy),
        .owner_o    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [2:0]  dm_op;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] rdata;
        logic        e_owner;
        logic [31:0] e_addr;
        logic        e_we;
        logic [2:0]  e_op;
        logic [31:0] e_wdata;
        logic [31:0] e_if_rdata;
        logic [31:0] e_dm_rdata;
    } vec_t;

    vec_t vecs[6];
    int   errors = 0;
    int   checks = 0;

    // Random-phase model state
    int          cyc;
    int          g;
    int          free_at;
    int          starve;
    bit          act;
    logic        m_owner;
    logic        m_we;
    logic [31:0] m_word;
    logic [31:0] e_addr;
    logic        e_we;
    logic [2:0]  e_op;
    logic [31:0] e_wdata;
    logic        e_owner;
    logic [31:0] e_if_rd;
    logic [31:0] e_dm_rd;
    logic        e_en;
    logic        e_busy;
    logic        e_ack;
    int          ng;
    logic [5:0]  starve_seq;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_op     = '0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, ".busy"}, busy, 0);
        chk({name, ".mem_en"}, mem_en, 0);
        chk({name, ".mem_we"}, mem_we, 0);
        chk({name, ".mem_op"}, mem_op, 0);
        chk({name, ".mem_addr"}, mem_addr, 0);
        chk({name, ".mem_wdata"}, mem_wdata, 0);
        chk({name, ".if_ack"}, if_ack, 0);
        chk({name, ".dm_ack"}, dm_ack, 0);
        chk({name, ".if_rdata"}, if_rdata, 0);
        chk({name, ".dm_rdata"}, dm_rdata, 0);
        chk({name, ".owner"}, owner, 0);
        chk({name, ".stalls"}, {if_stall, mem_stall}, 0);
    endtask

    // Starts in an idle cycle (c0) and ends in the idle cycle after the response (c5).
    task automatic run_vec(input vec_t v, input string name);
        if_req   = v.if_req;
        if_addr  = v.if_addr;
        dm_req   = v.dm_req;
        dm_we    = v.dm_we;
        dm_op    = v.dm_op;
        dm_addr  = v.dm_addr;
        dm_wdata = v.dm_wdata;
        #1;
        chk({name, ".c0_stall"}, {if_stall, mem_stall}, {v.if_req, v.dm_req});
        tick();
        chk({name, ".c1_en"}, {mem_en, busy}, 2'b11);
        chk({name, ".c1_addr"}, mem_addr, v.e_addr);
        chk({name, ".c1_we_op"}, {mem_we, mem_op}, {v.e_we, v.e_op});
        chk({name, ".c1_wdata"}, mem_wdata, v.e_wdata);
        chk({name, ".c1_owner"}, owner, v.e_owner);
        tick();
        chk({name, ".c2_en"}, mem_en, 0);
        tick();
        mem_rdata = v.rdata;
        chk({name, ".c3_ack"}, {if_ack, dm_ack}, 2'b00);
        tick();
        mem_rdata = 32'hA5A5A5A5;
        chk({name, ".c4_ack"}, {if_ack, dm_ack}, {~v.e_owner, v.e_owner});
        chk({name, ".c4_if_rdata"}, if_rdata, v.e_if_rdata);
        chk({name, ".c4_dm_rdata"}, dm_rdata, v.e_dm_rdata);
        chk({name, ".c4_stall"}, {if_stall, mem_stall}, {v.if_req & v.e_owner, 1'b0});
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        chk({name, ".c5_idle"}, {busy, if_ack, dm_ack, mem_en}, 4'b0000);
    endtask

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = $urandom;
    endtask

    task automatic new_dm();
        dm_req   = 1'b1;
        dm_we    = 1'($urandom_range(1));
        dm_op    = 3'($urandom_range(7));
        dm_addr  = $urandom;
        dm_wdata = $urandom;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h13,
                    1'b0, 32'h100, 1'b0, 3'd0, 32'h0, 32'h13, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 32'h55AA55AA,
                    1'b1, 32'h200, 1'b1, 3'b010, 32'hDEADBEEF, 32'h13, 32'h0};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 3'b101, 32'h304, 32'h11112222, 32'hCAFEF00D,
                    1'b1, 32'h304, 1'b0, 3'b101, 32'h11112222, 32'h13, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 32'h400, 1'b1, 1'b0, 3'b001, 32'h500, 32'h33334444, 32'h0BADF00D,
                    1'b1, 32'h500, 1'b0, 3'b001, 32'h33334444, 32'h13, 32'h0BADF00D};
        vecs[4] = '{1'b1, 32'h7FC, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h12345678,
                    1'b0, 32'h7FC, 1'b0, 3'd0, 32'h33334444, 32'h12345678, 32'h0BADF00D};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 3'd0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFF,
                    1'b1, 32'hFFFFFFFC, 1'b1, 3'd0, 32'h0, 32'h12345678, 32'h0BADF00D};

        // Reset: outputs quiet during and after reset with requests low
        rst = 1'b1;
        #1;
        chk_quiet("in_reset");
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk_quiet("post_reset");
            tick();
        end
        mem_rdata = 32'hA5A5A5A5;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Collision: DM first, IF granted at c5, if_ack at c9
        if_req   = 1'b1;
        if_addr  = 32'h900;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_op    = 3'b010;
        dm_addr  = 32'hA00;
        dm_wdata = 32'h0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("coll.c%0d_if_stall", k), if_stall, (k < 9));
            chk($sformatf("coll.c%0d_en", k), mem_en, (k == 1 || k == 6));
            chk($sformatf("coll.c%0d_acks", k), {if_ack, dm_ack}, {k == 9, k == 4});
            if (k == 1) chk("coll.c1_addr", mem_addr, 32'hA00);
            if (k == 6) chk("coll.c6_addr", mem_addr, 32'h900);
            mem_rdata = (k == 3) ? 32'h0000D00D : (k == 8) ? 32'h0000F00F : 32'hA5A5A5A5;
            if (k == 4) dm_req = 1'b0;
            if (k == 9) if_req = 1'b0;
            tick();
        end
        chk("coll.dm_rdata", dm_rdata, 32'h0000D00D);
        chk("coll.if_rdata", if_rdata, 32'h0000F00F);

        // Starvation: DM x4, then IF, then DM
        starve_seq = 6'b101111;
        ng         = 0;
        if_req     = 1'b1;
        if_addr    = 32'hC00;
        dm_req     = 1'b1;
        dm_addr    = 32'hD00;
        for (int k = 1; k < 35; k++) begin
            tick();
            mem_rdata = $urandom;
            if (mem_en) begin
                if (ng < 6) begin
                    chk($sformatf("starve.grant%0d_owner", ng), owner, starve_seq[ng]);
                end else begin
                    chk("starve.extra_grant", 1'b1, 1'b0);
                end
                ng++;
            end
            if (if_ack) if_req = 1'b0;
            if (dm_ack && ng >= 6) dm_req = 1'b0;
        end
        chk("starve.grant_count", ng, 6);

        // Reset mid-WAIT of a fetch: no ack, stale response discarded
        mem_rdata = 32'hA5A5A5A5;
        if_req    = 1'b1;
        if_addr   = 32'h100;
        tick();
        chk("rstmid.c1_en", mem_en, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("rstmid.c2", {busy, mem_en, if_ack}, 3'b000);
        if_req = 1'b0;
        tick();
        mem_rdata = 32'h00000013;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rstmid.after%0d", k), {busy, mem_en, if_ack, dm_ack}, 4'b0000);
            chk($sformatf("rstmid.if_rdata%0d", k), if_rdata, 0);
            tick();
            mem_rdata = 32'hA5A5A5A5;
        end
        run_vec(vecs[0], "rstmid.fresh");

        // Random traffic against a slot-level model
        do_reset();
        cyc = 0; g = -100; free_at = 0; starve = 0; act = 1'b0;
        m_owner = 1'b0; m_we = 1'b0; m_word = '0;
        e_addr = '0; e_we = 1'b0; e_op = '0; e_wdata = '0; e_owner = 1'b0;
        e_if_rd = '0; e_dm_rd = '0;
        for (int n = 0; n < 2500; n++) begin
            tick();
            cyc++;
            e_en   = act && (cyc == g + 1);
            e_busy = act && (cyc > g) && (cyc <= g + LAT + 2);
            e_ack  = act && (cyc == g + LAT + 2);
            if (e_ack && !m_owner) e_if_rd = m_word;
            if (e_ack && m_owner && !m_we) e_dm_rd = m_word;
            chk("rnd.busy", busy, e_busy);
            chk("rnd.mem_en", mem_en, e_en);
            chk("rnd.acks", {if_ack, dm_ack}, {e_ack & ~m_owner, e_ack & m_owner});
            chk("rnd.stalls", {if_stall, mem_stall},
                {if_req & ~(e_ack & ~m_owner), dm_req & ~(e_ack & m_owner)});
            chk("rnd.mem_addr", mem_addr, e_addr);
            chk("rnd.mem_we_op", {mem_we, mem_op}, {e_we, e_op});
            chk("rnd.mem_wdata", mem_wdata, e_wdata);
            chk("rnd.owner", owner, e_owner);
            chk("rnd.if_rdata", if_rdata, e_if_rd);
            chk("rnd.dm_rdata", dm_rdata, e_dm_rd);

            if (e_ack) begin
                if (m_owner) begin
                    if ($urandom_range(1) == 1) new_dm(); else dm_req = 1'b0;
                end else begin
                    if ($urandom_range(1) == 1) new_if(); else if_req = 1'b0;
                end
            end
            if (!if_req && $urandom_range(2) == 0) new_if();
            if (!dm_req && $urandom_range(2) == 0) new_dm();
            // Owner's fields wander after grant; the arbiter must not notice
            if (act && cyc > g && cyc < g + LAT + 2) begin
                if (m_owner) begin
                    dm_addr  = $urandom;
                    dm_wdata = $urandom;
                    dm_we    = 1'($urandom_range(1));
                    dm_op    = 3'($urandom_range(7));
                end else begin
                    if_addr = $urandom;
                end
            end
            mem_rdata = (act && cyc == g + 1 + LAT) ? m_word : 32'($urandom);

            if (cyc >= free_at && (if_req || dm_req)) begin
                if (if_req && dm_req) begin
                    if (starve == SMAX) begin
                        m_owner = 1'b0;
                        starve  = 0;
                    end else begin
                        m_owner = 1'b1;
                        starve  = starve + 1;
                    end
                end else begin
                    m_owner = dm_req;
                    starve  = 0;
                end
                act     = 1'b1;
                g       = cyc;
                free_at = cyc + LAT + 3;
                m_word  = $urandom;
                e_owner = m_owner;
                if (m_owner) begin
                    m_we    = dm_we;
                    e_addr  = dm_addr;
                    e_we    = dm_we;
                    e_op    = dm_op;
                    e_wdata = dm_wdata;
                end else begin
                    m_we   = 1'b0;
                    e_addr = if_addr;
                    e_we   = 1'b0;
                    e_op   = 3'b000;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
